// File: rtl/irq_controller.sv
// Machine external interrupt controller: synchronizes and edge-detects IRQ
// lines, arbitrates the lowest enabled index, and sequences trap/service/MRET.
module irq_controller #(
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        mie_i,
  input  logic               stall_i,
  input  logic               mret_i,
  output logic               trap_o,
  output logic [31:0]        mcause_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               in_service_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAP    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);
  localparam int WARM_W = SYNC_STAGES + 1;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
  logic [WARM_W-1:0]  warm_q, warm_d;

  logic [NUM_IRQ-1:0] sync_out;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] mie_en;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] clr;
  logic [3:0]         win;
  logic               unused_mie;

  assign unused_mie = ^mie_i;
  assign mie_en     = mie_i[16 +: NUM_IRQ];
  assign sync_out   = sync_q[SYNC_STAGES-1];

  // Edges stay masked until the synchronizer and history hold real samples,
  // so a line already high at reset release is not seen as a new edge.
  assign edge_det = warm_q[WARM_W-1] ? (sync_out & ~prev_q) : '0;
  assign elig     = pending_q & mie_en;

  always_comb begin
    sync_d[0] = irq_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_out;
    warm_d = {warm_q[WARM_W-2:0], 1'b1};
  end

  always_comb begin
    win = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win = 4'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mcause_d = mcause_q;
    clr      = '0;
    unique case (state_q)
      IDLE: begin
        if ((|elig) && !stall_i) begin
          state_d  = TRAP;
          idx_d    = win;
          mcause_d = 32'h8000_0010 + 32'(win);
        end
      end
      TRAP: begin
        state_d = SERVICE;
        clr     = ONE << idx_q;
      end
      SERVICE: begin
        if (mret_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge in the TRAP cycle wins over the clear of the serviced line.
  assign pending_d = (pending_q & ~clr) | edge_det;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      mcause_q  <= 32'd0;
      pending_q <= '0;
      prev_q    <= '0;
      warm_q    <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mcause_q  <= mcause_d;
      pending_q <= pending_d;
      prev_q    <= prev_d;
      warm_q    <= warm_d;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  always_comb begin
    trap_o       = (state_q == TRAP);
    in_service_o = (state_q != IDLE);
    mcause_o     = mcause_q;
    irq_ack_o    = trap_o ? (ONE << idx_q) : '0;
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: trap timing, priority, stall,
// masking, set/clear collision, reset mid-service and level-held lines.
module tb_irq_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] irq_i;
  logic [31:0] mie_i;
  logic        stall_i;
  logic        mret_i;
  logic        trap_o;
  logic [31:0] mcause_o;
  logic [15:0] irq_ack_o;
  logic        in_service_o;

  int nvec;
  int nerr;
  int trap_cnt;
  int n;
  int base;

  irq_controller #(
    .NUM_IRQ(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irq_i(irq_i),
    .mie_i(mie_i),
    .stall_i(stall_i),
    .mret_i(mret_i),
    .trap_o(trap_o),
    .mcause_o(mcause_o),
    .irq_ack_o(irq_ack_o),
    .in_service_o(in_service_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && trap_o) trap_cnt = trap_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Returns the number of edges until trap_o is seen, or -1 on timeout.
  task automatic wait_trap(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (trap_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_mret();
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    trap_cnt = 0;
    rst_n    = 1'b0;
    irq_i    = '0;
    mie_i    = '0;
    stall_i  = 1'b0;
    mret_i   = 1'b0;
    ticks(3);
    chk("rst_trap", 32'(trap_o), 32'd0);
    chk("rst_ack", 32'(irq_ack_o), 32'd0);
    chk("rst_insvc", 32'(in_service_o), 32'd0);
    chk("rst_mcause", mcause_o, 32'd0);
    rst_n = 1'b1;
    ticks(5);

    // basic trap
    mie_i    = 32'h0001_0000;
    irq_i[0] = 1'b1;
    wait_trap(20, n);
    chk("basic_lat", 32'(n), 32'd4);
    chk("basic_mcause", mcause_o, 32'h8000_0010);
    chk("basic_ack", 32'(irq_ack_o), 32'h0001);
    chk("basic_insvc", 32'(in_service_o), 32'd1);
    irq_i[0] = 1'b0;
    tick();
    chk("basic_pulse", 32'(trap_o), 32'd0);
    chk("basic_ack_off", 32'(irq_ack_o), 32'd0);
    chk("basic_hold", mcause_o, 32'h8000_0010);
    chk("basic_svc", 32'(in_service_o), 32'd1);
    do_mret();
    chk("basic_idle", 32'(in_service_o), 32'd0);
    ticks(5);

    // priority and resume
    base     = trap_cnt;
    mie_i    = 32'h0024_0000;
    irq_i[5] = 1'b1;
    irq_i[2] = 1'b1;
    wait_trap(20, n);
    chk("prio_lat", 32'(n), 32'd4);
    chk("prio_mcause1", mcause_o, 32'h8000_0012);
    chk("prio_ack1", 32'(irq_ack_o), 32'h0004);
    irq_i = '0;
    ticks(3);
    do_mret();
    wait_trap(5, n);
    chk("prio_resume", 32'(n), 32'd1);
    chk("prio_mcause2", mcause_o, 32'h8000_0015);
    chk("prio_ack2", 32'(irq_ack_o), 32'h0020);
    tick();
    do_mret();
    ticks(20);
    chk("prio_count", 32'(trap_cnt - base), 32'd2);

    // stall
    base     = trap_cnt;
    mie_i    = 32'h0008_0000;
    stall_i  = 1'b1;
    irq_i[3] = 1'b1;
    ticks(10);
    chk("stall_none", 32'(trap_cnt - base), 32'd0);
    chk("stall_idle", 32'(in_service_o), 32'd0);
    stall_i = 1'b0;
    wait_trap(5, n);
    chk("stall_release", 32'(n), 32'd1);
    chk("stall_mcause", mcause_o, 32'h8000_0013);
    irq_i[3] = 1'b0;
    tick();
    do_mret();
    ticks(5);

    // disabled line keeps its pending bit
    base     = trap_cnt;
    mie_i    = 32'h0000_0000;
    irq_i[3] = 1'b1;
    ticks(3);
    irq_i[3] = 1'b0;
    ticks(12);
    chk("dis_none", 32'(trap_cnt - base), 32'd0);
    mie_i = 32'h0008_0000;
    wait_trap(5, n);
    chk("dis_enable", 32'(n), 32'd1);
    chk("dis_mcause", mcause_o, 32'h8000_0013);
    tick();
    do_mret();
    ticks(5);

    // second edge on line 1 lands in its own TRAP cycle
    base     = trap_cnt;
    mie_i    = 32'h0002_0000;
    irq_i[1] = 1'b1;
    tick();
    irq_i[1] = 1'b0;
    tick();
    irq_i[1] = 1'b1;
    ticks(2);
    chk("coll_trap", 32'(trap_o), 32'd1);
    chk("coll_mcause1", mcause_o, 32'h8000_0011);
    irq_i[1] = 1'b0;
    ticks(3);
    do_mret();
    wait_trap(5, n);
    chk("coll_retrap", 32'(n), 32'd1);
    chk("coll_ack2", 32'(irq_ack_o), 32'h0002);
    tick();
    do_mret();
    ticks(15);
    chk("coll_count", 32'(trap_cnt - base), 32'd2);

    // reset while in service with lines 4 and 7 pending
    mie_i    = 32'h0091_0000;
    irq_i[0] = 1'b1;
    wait_trap(20, n);
    chk("rsvc_trap0", 32'(n), 32'd4);
    irq_i[0] = 1'b0;
    irq_i[4] = 1'b1;
    irq_i[7] = 1'b1;
    ticks(6);
    chk("rsvc_in_svc", 32'(in_service_o), 32'd1);
    irq_i = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rsvc_trap", 32'(trap_o), 32'd0);
    chk("rsvc_ack", 32'(irq_ack_o), 32'd0);
    chk("rsvc_insvc", 32'(in_service_o), 32'd0);
    chk("rsvc_mcause", mcause_o, 32'd0);
    base = trap_cnt;
    ticks(20);
    chk("rsvc_quiet", 32'(trap_cnt - base), 32'd0);
    irq_i[4] = 1'b1;
    wait_trap(20, n);
    chk("rsvc_fresh", 32'(n), 32'd4);
    chk("rsvc_mcause2", mcause_o, 32'h8000_0014);
    irq_i[4] = 1'b0;
    tick();
    do_mret();
    ticks(5);

    // level-held line triggers once
    base     = trap_cnt;
    mie_i    = 32'h0040_0000;
    irq_i[6] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mret_i = (i % 5 == 4);
      tick();
    end
    mret_i   = 1'b0;
    irq_i[6] = 1'b0;
    ticks(5);
    chk("level_once", 32'(trap_cnt - base), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
